// File: rtl/i2c_master_multibyte.sv
// rtl/i2c_master_multibyte.sv - multi-byte I2C master with read, probe and NACK abort.
// Optional SCL clock stretching is enabled by defining I2C_CLOCK_STRETCH_EN.
module i2c_master_multibyte #(
    parameter int MAX_BYTES      = 4,
    parameter int CLKS_PER_PHASE = 1,
    parameter int COUNT_W        = 5
) (
    input  logic                   clock_100khz,
    input  logic                   reset,
    input  logic                   start,
    input  logic [6:0]             slave_address,
    input  logic                   rw,
    input  logic [COUNT_W-1:0]     num_bytes,
    input  logic [8*MAX_BYTES-1:0] write_data,
    output logic [8*MAX_BYTES-1:0] read_data,
    output logic                   busy,
    output logic                   done,
    output logic                   nack_error,
    input  logic                   i2c_serial_data_input,
    output logic                   i2c_serial_data_output,
    output logic                   i2c_serial_data_oe,
    output logic                   i2c_serial_clock,
    input  logic                   i2c_serial_clock_input
);
    localparam int DW = 8 * MAX_BYTES;
    localparam int TW = (CLKS_PER_PHASE > 1) ? $clog2(CLKS_PER_PHASE) : 1;
`ifdef I2C_CLOCK_STRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START_A, S_START_B, S_BIT_LO, S_BIT_HI, S_STOP_A, S_STOP_B, S_STOP_C
    } state_t;

    state_t               state, state_next;
    logic [TW-1:0]        timer;
    logic [3:0]           slot;
    logic [COUNT_W-1:0]   byte_idx, n_q;
    logic [7:0]           addr_q;
    logic                 rw_q;
    logic [DW-1:0]        wdata_q, rdata_q;
    logic                 nack_q, done_q;

    logic                 scl_high, hold, phase_end, tx_byte, last_byte, tx_bit, release_sda;
    logic [7:0]           bit_pos;
    logic [7:0]           addr_sh;
    logic [DW-1:0]        wdata_sh;

    always_comb begin
        scl_high  = (state == S_START_A) || (state == S_BIT_HI) ||
                    (state == S_STOP_B)  || (state == S_STOP_C);
        // A slave holding SCL low freezes the timer of any SCL-high phase.
        hold      = STRETCH_EN && scl_high && !i2c_serial_clock_input;
        phase_end = (timer == TW'(CLKS_PER_PHASE - 1)) && !hold;
        tx_byte   = (byte_idx == '0) || !rw_q;
        last_byte = (byte_idx == n_q);
        bit_pos   = 8'(8 * (int'(byte_idx) - 1) + 7 - int'(slot));
        addr_sh   = addr_q >> (4'd7 - slot);
        wdata_sh  = wdata_q >> bit_pos;
        tx_bit    = (byte_idx == '0) ? addr_sh[0] : wdata_sh[0];
        // Slot 8 of a read byte: ACK all but the last byte, which gets NACK (released).
        if (slot == 4'd8) release_sda = tx_byte ? 1'b1 : last_byte;
        else              release_sda = tx_byte ? tx_bit : 1'b1;
    end

    always_comb begin
        state_next         = state;
        i2c_serial_clock   = 1'b1;
        i2c_serial_data_oe = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_START_A;
            S_START_A: begin
                i2c_serial_data_oe = 1'b1;
                if (phase_end) state_next = S_START_B;
            end
            S_START_B: begin
                i2c_serial_clock   = 1'b0;
                i2c_serial_data_oe = 1'b1;
                if (phase_end) state_next = S_BIT_LO;
            end
            S_BIT_LO: begin
                i2c_serial_clock   = 1'b0;
                i2c_serial_data_oe = !release_sda;
                if (phase_end) state_next = S_BIT_HI;
            end
            S_BIT_HI: begin
                i2c_serial_data_oe = !release_sda;
                if (phase_end) begin
                    if (slot == 4'd8 && ((tx_byte && i2c_serial_data_input) || last_byte))
                        state_next = S_STOP_A;
                    else
                        state_next = S_BIT_LO;
                end
            end
            S_STOP_A: begin
                i2c_serial_clock   = 1'b0;
                i2c_serial_data_oe = 1'b1;
                if (phase_end) state_next = S_STOP_B;
            end
            S_STOP_B: begin
                i2c_serial_data_oe = 1'b1;
                if (phase_end) state_next = S_STOP_C;
            end
            S_STOP_C: if (phase_end) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_100khz) begin
        if (reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            slot     <= '0;
            byte_idx <= '0;
            n_q      <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state == S_STOP_C) && phase_end;
            if (state == S_IDLE || phase_end) timer <= '0;
            else if (!hold)                   timer <= timer + 1'b1;
            if (state == S_IDLE && start) begin
                addr_q   <= {slave_address, rw};
                rw_q     <= rw;
                n_q      <= (num_bytes > COUNT_W'(MAX_BYTES)) ? COUNT_W'(MAX_BYTES) : num_bytes;
                wdata_q  <= write_data;
                rdata_q  <= '0;
                nack_q   <= 1'b0;
                slot     <= '0;
                byte_idx <= '0;
            end else if (state == S_BIT_HI && phase_end) begin
                if (slot == 4'd8) begin
                    slot     <= '0;
                    byte_idx <= byte_idx + 1'b1;
                    if (tx_byte && i2c_serial_data_input) nack_q <= 1'b1;
                end else begin
                    slot <= slot + 1'b1;
                    if (!tx_byte) rdata_q <= rdata_q | (DW'(i2c_serial_data_input) << bit_pos);
                end
            end
        end
    end

    assign busy                   = (state != S_IDLE);
    assign done                   = done_q;
    assign nack_error             = nack_q;
    assign read_data              = rdata_q;
    assign i2c_serial_data_output = !i2c_serial_data_oe;
endmodule

// File: tb/tb_i2c_master_multibyte.sv
// tb/tb_i2c_master_multibyte.sv - randomized self-checking bench with an I2C slave model.
module tb_i2c_master_multibyte;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, start = 1'b0, rw = 1'b0;
    logic [6:0]  addr = '0;
    logic [4:0]  num_bytes = '0;
    logic [31:0] wdata = '0, rdata;
    logic        busy, done, nack, scl, sda_out, sda_oe, scl_in;
    logic        slave_low = 1'b0;
    wire         sda_line = (sda_oe || slave_low) ? 1'b0 : 1'b1;
    int          hold_cnt = 0;
    bit          stretch_req = 1'b0, stretch_used = 1'b0;
    assign scl_in = scl && (hold_cnt == 0);

    i2c_master_multibyte #(.MAX_BYTES(4), .CLKS_PER_PHASE(1), .COUNT_W(5)) dut (
        .clock_100khz(clk), .reset(reset), .start(start), .slave_address(addr), .rw(rw),
        .num_bytes(num_bytes), .write_data(wdata), .read_data(rdata), .busy(busy), .done(done),
        .nack_error(nack), .i2c_serial_data_input(sda_line), .i2c_serial_data_output(sda_out),
        .i2c_serial_data_oe(sda_oe), .i2c_serial_clock(scl), .i2c_serial_clock_input(scl_in));

    logic        d2_start = 1'b0, d2_sda_in = 1'b0;
    logic [4:0]  d2_num = '0;
    logic [31:0] d2_rdata;
    logic        d2_busy, d2_done, d2_nack, d2_scl, d2_out, d2_oe;

    i2c_master_multibyte #(.MAX_BYTES(4), .CLKS_PER_PHASE(3), .COUNT_W(5)) dut2 (
        .clock_100khz(clk), .reset(reset), .start(d2_start), .slave_address(7'h50), .rw(1'b0),
        .num_bytes(d2_num), .write_data(32'hC3A5_5A3C), .read_data(d2_rdata), .busy(d2_busy),
        .done(d2_done), .nack_error(d2_nack), .i2c_serial_data_input(d2_sda_in),
        .i2c_serial_data_output(d2_out), .i2c_serial_data_oe(d2_oe), .i2c_serial_clock(d2_scl),
        .i2c_serial_clock_input(d2_scl));

    int checks = 0, errors = 0;
    int busy_total = 0, done_total = 0, busy2_total = 0, done2_total = 0;
    int k = 0;
    bit prev_scl = 1'b1, prev_sda = 1'b1;
    bit bits_q[$], exp_q[$];
    bit s_ack = 1'b1, s_rw = 1'b0;
    int s_n = 0;
    logic [7:0] s_rbytes [4];

    // Slave: ACKs master bytes and returns s_rbytes on reads, deciding SDA only while SCL is low.
    function automatic bit slave_drive(input int kk);
        int b, sl;
        b = kk / 9;
        sl = kk % 9;
        if (!s_ack) return 1'b0;
        if (sl == 8) return (b == 0) || (!s_rw && b <= s_n);
        if (s_rw && b >= 1 && b <= s_n) return !s_rbytes[b-1][7-sl];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        bit cs, cd;
        cs = scl;
        cd = sda_line;
        if (busy) busy_total++;
        if (done) done_total++;
        if (d2_busy) busy2_total++;
        if (d2_done) done2_total++;
        if (hold_cnt > 0) hold_cnt--;
        if (cs && prev_scl && prev_sda && !cd) begin
            k = 0;
            bits_q.delete();
        end else if (cs && !prev_scl) begin
            bits_q.push_back(cd);
            if (stretch_req && !stretch_used && k == 3) begin
                hold_cnt = 10;
                stretch_used = 1'b1;
            end
            k++;
        end
        if (reset) slave_low = 1'b0;
        else if (!cs) slave_low = slave_drive(k);
        prev_scl = cs;
        prev_sda = cd;
    end

    // Expected bit seen at every SCL rise: bytes with ACK slots, then the STOP_B rise with SDA low.
    task automatic build_exp(input logic [6:0] a, input bit r, input int n, input logic [31:0] wd, input bit ack);
        logic [7:0] b;
        exp_q.delete();
        b = {a, r};
        for (int j = 7; j >= 0; j--) exp_q.push_back(b[j]);
        exp_q.push_back(!ack);
        if (ack) begin
            for (int i = 0; i < n; i++) begin
                b = r ? s_rbytes[i] : wd[8*i +: 8];
                for (int j = 7; j >= 0; j--) exp_q.push_back(b[j]);
                exp_q.push_back(r ? (i == n - 1) : 1'b0);
            end
        end
        exp_q.push_back(1'b0);
    endtask

    function automatic int stream_diff();
        int d = 0;
        if (bits_q.size() != exp_q.size()) return -1;
        foreach (exp_q[i]) if (bits_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    function automatic logic [31:0] exp_rdata(input bit r, input int n);
        logic [31:0] v = '0;
        if (r) for (int i = 0; i < n; i++) v[8*i +: 8] = s_rbytes[i];
        return v;
    endfunction

    task automatic run_txn(input logic [6:0] a, input bit r, input logic [4:0] n, input logic [31:0] wd,
                           output bit to, output int cyc, output int dn);
        int b0, d0;
        @(negedge clk);
        s_rw = r;
        s_n = (n > 4) ? 4 : int'(n);
        b0 = busy_total;
        d0 = done_total;
        addr = a; rw = r; num_bytes = n; wdata = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin to = 1'b0; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cyc = busy_total - b0;
        dn = done_total - d0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (nack !== 1'b0) begin errors++; $display("FAIL reset_nack got %b want 0", nack); end
        checks++; if ({scl, sda_oe, sda_out} !== 3'b101) begin errors++; $display("FAIL reset_bus got %b want 101", {scl, sda_oe, sda_out}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        reset = 1'b0;
    endtask

    task automatic test_write();
        bit to; int cyc, dn, sd;
        s_ack = 1'b1;
        build_exp(7'h39, 1'b0, 2, 32'h0000_06AF, 1'b1);
        run_txn(7'h39, 1'b0, 5'd2, 32'h0000_06AF, to, cyc, dn);
        sd = stream_diff();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL write_timeout got %b want 0", to); end
        checks++; if (cyc !== 59) begin errors++; $display("FAIL write_busy_cycles got %0d want 59", cyc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL write_done_pulses got %0d want 1", dn); end
        checks++; if (nack !== 1'b0) begin errors++; $display("FAIL write_nack got %b want 0", nack); end
        checks++; if (sd !== 0) begin errors++; $display("FAIL write_stream diff %0d (size %0d want %0d)", sd, bits_q.size(), exp_q.size()); end
    endtask

    task automatic test_read();
        bit to; int cyc, dn, sd;
        s_ack = 1'b1;
        s_rbytes[0] = 8'h12; s_rbytes[1] = 8'h34; s_rbytes[2] = 8'h56; s_rbytes[3] = 8'hFF;
        build_exp(7'h39, 1'b1, 3, 32'h0, 1'b1);
        run_txn(7'h39, 1'b1, 5'd3, 32'hDEAD_BEEF, to, cyc, dn);
        sd = stream_diff();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL read_timeout got %b want 0", to); end
        checks++; if (rdata !== 32'h0056_3412) begin errors++; $display("FAIL read_data got %h want 00563412", rdata); end
        checks++; if (cyc !== 77) begin errors++; $display("FAIL read_busy_cycles got %0d want 77", cyc); end
        checks++; if (sd !== 0) begin errors++; $display("FAIL read_stream diff %0d (size %0d want %0d)", sd, bits_q.size(), exp_q.size()); end
    endtask

    task automatic test_addr_nack();
        bit to; int cyc, dn, sd;
        s_ack = 1'b0;
        build_exp(7'h2A, 1'b0, 4, 32'h1122_3344, 1'b0);
        run_txn(7'h2A, 1'b0, 5'd4, 32'h1122_3344, to, cyc, dn);
        sd = stream_diff();
        checks++; if (nack !== 1'b1) begin errors++; $display("FAIL nack_flag got %b want 1", nack); end
        checks++; if (cyc !== 23) begin errors++; $display("FAIL nack_busy_cycles got %0d want 23", cyc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL nack_done_pulses got %0d want 1", dn); end
        checks++; if (sd !== 0) begin errors++; $display("FAIL nack_stream diff %0d (size %0d want %0d)", sd, bits_q.size(), exp_q.size()); end
        s_ack = 1'b1;
    endtask

    task automatic test_probe();
        bit to; int cyc, dn, sd, b0;
        build_exp(7'h44, 1'b1, 0, 32'h0, 1'b1);
        run_txn(7'h44, 1'b1, 5'd0, 32'h0, to, cyc, dn);
        sd = stream_diff();
        checks++; if (cyc !== 23) begin errors++; $display("FAIL probe_busy_cycles got %0d want 23", cyc); end
        checks++; if (nack !== 1'b0) begin errors++; $display("FAIL probe_nack got %b want 0", nack); end
        checks++; if (sd !== 0) begin errors++; $display("FAIL probe_stream diff %0d", sd); end
        for (int t = 0; t < 2; t++) begin
            int want;
            want = (t == 0) ? 69 : 285;
            @(negedge clk);
            b0 = busy2_total;
            d2_num = (t == 0) ? 5'd0 : 5'd7;
            d2_start = 1'b1;
            @(negedge clk);
            d2_start = 1'b0;
            to = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if (d2_done) begin to = 1'b0; break; end
                @(negedge clk);
            end
            @(negedge clk);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL slow_timeout_%0d got %b want 0", t, to); end
            checks++; if (busy2_total - b0 !== want) begin errors++; $display("FAIL slow_busy_cycles_%0d got %0d want %0d", t, busy2_total - b0, want); end
            checks++; if (d2_nack !== 1'b0) begin errors++; $display("FAIL slow_nack_%0d got %b want 0", t, d2_nack); end
        end
    endtask

    task automatic test_random();
        bit to; int cyc, dn, sd, neff;
        logic [6:0] a; bit r; logic [4:0] n; logic [31:0] wd;
        s_ack = 1'b1;
        for (int it = 0; it < 6; it++) begin
            a = 7'($urandom_range(0, 127));
            r = 1'($urandom_range(0, 1));
            n = 5'($urandom_range(0, 6));
            wd = $urandom;
            for (int i = 0; i < 4; i++) s_rbytes[i] = 8'($urandom);
            neff = (n > 4) ? 4 : int'(n);
            build_exp(a, r, neff, wd, 1'b1);
            run_txn(a, r, n, wd, to, cyc, dn);
            sd = stream_diff();
            checks++; if (cyc !== 5 + 18 * (neff + 1)) begin errors++; $display("FAIL rand%0d_busy_cycles got %0d want %0d", it, cyc, 5 + 18 * (neff + 1)); end
            checks++; if (sd !== 0) begin errors++; $display("FAIL rand%0d_stream diff %0d", it, sd); end
            checks++; if (rdata !== exp_rdata(r, neff)) begin errors++; $display("FAIL rand%0d_rdata got %h want %h", it, rdata, exp_rdata(r, neff)); end
            checks++; if ({dn, nack} !== {32'd1, 1'b0}) begin errors++; $display("FAIL rand%0d_done_nack got %0d/%b want 1/0", it, dn, nack); end
        end
    endtask

    task automatic test_reset_mid();
        bit to; int cyc, dn, sd, d0;
        bit reached;
        @(negedge clk);
        s_rw = 1'b0; s_n = 2;
        addr = 7'h39; rw = 1'b0; num_bytes = 5'd2; wdata = 32'h0000_06AF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bits_q.size() >= 11) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL midreset_reach got %b want 1", reached); end
        d0 = done_total;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({scl, sda_oe, busy} !== 3'b100) begin errors++; $display("FAIL midreset_bus got %b want 100", {scl, sda_oe, busy}); end
        repeat (5) @(negedge clk);
        checks++; if (done_total - d0 !== 0) begin errors++; $display("FAIL midreset_done got %0d want 0", done_total - d0); end
        build_exp(7'h39, 1'b0, 2, 32'h0000_06AF, 1'b1);
        run_txn(7'h39, 1'b0, 5'd2, 32'h0000_06AF, to, cyc, dn);
        sd = stream_diff();
        checks++; if (cyc !== 59 || sd !== 0) begin errors++; $display("FAIL midreset_rerun cycles %0d diff %0d want 59/0", cyc, sd); end
    endtask

    task automatic test_back_to_back();
        bit to1, to2; int b0, d0;
        @(negedge clk);
        s_rw = 1'b0; s_n = 1;
        b0 = busy_total; d0 = done_total;
        addr = 7'h1C; rw = 1'b0; num_bytes = 5'd1; wdata = 32'h0000_00C5; start = 1'b1;
        @(negedge clk);
        to1 = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (done) begin to1 = 1'b0; break; end
            @(negedge clk);
        end
        checks++; if ({to1, busy} !== 2'b00) begin errors++; $display("FAIL b2b_gap got to=%b busy=%b want 0 0", to1, busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got busy=%b want 1", busy); end
        start = 1'b0;
        to2 = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (done) begin to2 = 1'b0; break; end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++; if (to2 !== 1'b0 || done_total - d0 !== 2) begin errors++; $display("FAIL b2b_done got to=%b pulses %0d want 0/2", to2, done_total - d0); end
        checks++; if (busy_total - b0 !== 82) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 82", busy_total - b0); end
    endtask

`ifdef I2C_CLOCK_STRETCH_EN
    task automatic test_stretch();
        bit to; int cyc, dn, sd;
        s_ack = 1'b1;
        build_exp(7'h39, 1'b0, 1, 32'h0000_005A, 1'b1);
        stretch_req = 1'b1;
        run_txn(7'h39, 1'b0, 5'd1, 32'h0000_005A, to, cyc, dn);
        stretch_req = 1'b0;
        sd = stream_diff();
        checks++; if (cyc !== 51) begin errors++; $display("FAIL stretch_busy_cycles got %0d want 51", cyc); end
        checks++; if (sd !== 0) begin errors++; $display("FAIL stretch_stream diff %0d", sd); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_probe();
        test_random();
        test_reset_mid();
        test_back_to_back();
`ifdef I2C_CLOCK_STRETCH_EN
        test_stretch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
